// File: rtl/exu_muldiv_pkg.sv
// exu_muldiv_pkg
//   Shared definitions for the iterative RV M-extension unit.
//   - M-extension funct3 operation codes (MD_MUL .. MD_REMU)
//   - default operand width and funct width
//   - FSM state encoding (MD_IDLE, MD_CALC, MD_DONE)
//   - small decode helpers for operand signedness
package exu_muldiv_pkg;

    localparam int ISA_WIDTH          = 32;
    localparam int MD_XLEN_DEFAULT    = ISA_WIDTH;
    localparam int MULDIV_FUNCT_WIDTH = 3;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // rs1 is interpreted as two's complement for these operations
    function automatic logic md_src1_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is interpreted as two's complement for these operations
    function automatic logic md_src2_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/exu_div_iter.sv
// exu_div_iter
//   One restoring-division step. The partial remainder is shifted left by
//   one, the next dividend bit enters at the bottom, and the divisor is
//   subtracted when it fits; the outcome of that trial is the quotient bit.
// Ports
//   rem_in       [XLEN:0]    partial remainder before the step
//   dividend_bit             next dividend bit (MSB first)
//   divisor      [XLEN-1:0]  divisor magnitude
//   rem_out      [XLEN:0]    partial remainder after the step
//   quot_bit                 quotient bit produced by the step
module exu_div_iter
    import exu_muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN_DEFAULT
) (
    input  logic [XLEN:0]   rem_in,
    input  logic            dividend_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic            quot_bit
);

    logic [XLEN+1:0] shifted_s;
    logic [XLEN+1:0] divisor_s;

    assign shifted_s = {rem_in, dividend_bit};
    assign divisor_s = {2'b00, divisor};
    assign quot_bit  = (shifted_s >= divisor_s);

    // Restore (keep the shifted value) when the divisor does not fit
    always_comb begin
        if (quot_bit) begin
            rem_out = (XLEN+1)'(shifted_s - divisor_s);
        end else begin
            rem_out = shifted_s[XLEN:0];
        end
    end

endmodule

// File: rtl/exu_muldiv.sv
// exu_muldiv
//   Iterative RV M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//   Operands are reduced to magnitudes at accept; a radix-2 shift-add
//   multiplier or a restoring divider then runs one bit per clock and the
//   sign fix-up is applied on the last step. One operation in flight.
//   Divide-by-zero, signed overflow and unknown funct codes finish at once.
// Configuration
//   MULDIV_FAST_MUL_EN : multiplies use a combinational XLEN x XLEN product
//                        and complete one clock after accept. Division is
//                        unaffected. Undefined: all multiplies iterate.
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   flush      in   cancel the in-flight operation
//   in_valid   in   funct/src1/src2 valid
//   in_ready   out  unit idle, can accept
//   funct      in   [FUNCT_WIDTH-1:0] RV funct3 of the M operation
//   src1       in   [XLEN-1:0] rs1 (dividend / multiplicand)
//   src2       in   [XLEN-1:0] rs2 (divisor / multiplier)
//   out_valid  out  result valid
//   out_ready  in   consumer takes the result
//   result     out  [XLEN-1:0] selected result word
//   busy       out  unit not idle
module exu_muldiv
    import exu_muldiv_pkg::*;
#(
    parameter int XLEN        = MD_XLEN_DEFAULT,
    parameter int FUNCT_WIDTH = MULDIV_FUNCT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FUNCT_WIDTH-1:0] funct,
    input  logic [XLEN-1:0]        src1,
    input  logic [XLEN-1:0]        src2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        result,
    output logic                   busy
);

    localparam int CNT_W = $clog2(XLEN);

    md_state_e         state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [2:0]        op_r, op_s;
    logic              neg_r, neg_s;
    logic [XLEN-1:0]   op_a_r, op_a_s;
    logic [XLEN-1:0]   op_b_r, op_b_s;
    logic [XLEN-1:0]   acc_hi_r, acc_hi_s;
    logic [XLEN-1:0]   acc_lo_r, acc_lo_s;
    logic [XLEN:0]     rem_r, rem_s;
    logic [XLEN-1:0]   result_r, result_s;
    logic              in_ready_r, out_valid_r, busy_r;

    // Input decode
    logic [2:0]        in_op_s;
    logic              funct_known_s;
    logic              s1_neg_s, s2_neg_s, neg_in_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s;
    logic              div_zero_s, div_ovf_s;

    // One-step datapath
    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_rem_s;
    logic              div_q_s;
    logic [XLEN-1:0]   step_hi_s, step_lo_s;
    logic [XLEN:0]     step_rem_s;

    // Sign fix-up and result word selection from unsigned magnitudes
    function automatic logic [XLEN-1:0] md_finish(
        input logic [2:0]      op,
        input logic            neg,
        input logic [XLEN-1:0] hi,
        input logic [XLEN-1:0] lo,
        input logic [XLEN-1:0] rem
    );
        logic [2*XLEN-1:0] prod;
        prod = neg ? -{hi, lo} : {hi, lo};
        case (op)
            MD_MUL:                      md_finish = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: md_finish = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             md_finish = neg ? -lo : lo;
            MD_REM, MD_REMU:             md_finish = neg ? -rem : rem;
            default:                     md_finish = {XLEN{1'b0}};
        endcase
    endfunction

    assign in_op_s = funct[2:0];

    generate
        if (FUNCT_WIDTH > 3) begin : g_wide_funct
            assign funct_known_s = ~|funct[FUNCT_WIDTH-1:3];
        end else begin : g_narrow_funct
            assign funct_known_s = 1'b1;
        end
    endgenerate

    assign s1_neg_s = md_src1_signed(in_op_s) & src1[XLEN-1];
    assign s2_neg_s = md_src2_signed(in_op_s) & src2[XLEN-1];
    assign a_mag_s  = s1_neg_s ? -src1 : src1;
    assign b_mag_s  = s2_neg_s ? -src2 : src2;
    // Remainder follows the dividend; quotient/product negate when signs differ
    assign neg_in_s = (in_op_s == MD_REM) ? s1_neg_s : (s1_neg_s ^ s2_neg_s);

    assign div_zero_s = in_op_s[2] && (src2 == {XLEN{1'b0}});
    assign div_ovf_s  = ((in_op_s == MD_DIV) || (in_op_s == MD_REM)) &&
                        (src1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (src2 == {XLEN{1'b1}});

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod_s;
    assign fast_prod_s = {{XLEN{1'b0}}, a_mag_s} * {{XLEN{1'b0}}, b_mag_s};
`endif

    exu_div_iter #(
        .XLEN (XLEN)
    ) u_div_iter (
        .rem_in       (rem_r),
        .dividend_bit (acc_lo_r[XLEN-1]),
        .divisor      (op_b_r),
        .rem_out      (div_rem_s),
        .quot_bit     (div_q_s)
    );

    // Multiplier bit 0 selects whether the multiplicand is added this step
    assign mul_sum_s = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, op_a_r} : {(XLEN+1){1'b0}});

    // Next accumulator state for one multiply or divide iteration
    always_comb begin
        if (op_r[2]) begin
            step_hi_s  = acc_hi_r;
            step_lo_s  = {acc_lo_r[XLEN-2:0], div_q_s};
            step_rem_s = div_rem_s;
        end else begin
            step_hi_s  = mul_sum_s[XLEN:1];
            step_lo_s  = {mul_sum_s[0], acc_lo_r[XLEN-1:1]};
            step_rem_s = rem_r;
        end
    end

    // FSM next state and datapath register updates
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        op_s     = op_r;
        neg_s    = neg_r;
        op_a_s   = op_a_r;
        op_b_s   = op_b_r;
        acc_hi_s = acc_hi_r;
        acc_lo_s = acc_lo_r;
        rem_s    = rem_r;
        result_s = result_r;
        if (flush) begin
            state_s = MD_IDLE;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (in_valid) begin
                        op_s  = in_op_s;
                        neg_s = neg_in_s;
                        cnt_s = {CNT_W{1'b0}};
                        if (!funct_known_s) begin
                            result_s = {XLEN{1'b0}};
                            state_s  = MD_DONE;
                        end else if (div_zero_s) begin
                            result_s = in_op_s[1] ? src1 : {XLEN{1'b1}};
                            state_s  = MD_DONE;
                        end else if (div_ovf_s) begin
                            result_s = in_op_s[1] ? {XLEN{1'b0}} : src1;
                            state_s  = MD_DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!in_op_s[2]) begin
                            result_s = md_finish(in_op_s, neg_in_s, fast_prod_s[2*XLEN-1:XLEN],
                                                 fast_prod_s[XLEN-1:0], {XLEN{1'b0}});
                            state_s  = MD_DONE;
                        end
`endif
                        else begin
                            // Multiply: multiplier shifts out of acc_lo.
                            // Divide: dividend shifts out of acc_lo, quotient shifts in.
                            op_a_s   = a_mag_s;
                            op_b_s   = b_mag_s;
                            acc_hi_s = {XLEN{1'b0}};
                            acc_lo_s = in_op_s[2] ? a_mag_s : b_mag_s;
                            rem_s    = {(XLEN+1){1'b0}};
                            state_s  = MD_CALC;
                        end
                    end else begin
                        state_s = MD_IDLE;
                    end
                end
                MD_CALC: begin
                    acc_hi_s = step_hi_s;
                    acc_lo_s = step_lo_s;
                    rem_s    = step_rem_s;
                    cnt_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_W'(XLEN-1)) begin
                        // Last step: apply the sign fix-up to the fresh step outputs
                        result_s = md_finish(op_r, neg_r, step_hi_s, step_lo_s, step_rem_s[XLEN-1:0]);
                        state_s  = MD_DONE;
                    end else begin
                        state_s  = MD_CALC;
                    end
                end
                MD_DONE: begin
                    if (out_ready) begin
                        state_s = MD_IDLE;
                    end else begin
                        state_s = MD_DONE;
                    end
                end
                default: begin
                    state_s = MD_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= MD_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            op_r        <= 3'd0;
            neg_r       <= 1'b0;
            op_a_r      <= {XLEN{1'b0}};
            op_b_r      <= {XLEN{1'b0}};
            acc_hi_r    <= {XLEN{1'b0}};
            acc_lo_r    <= {XLEN{1'b0}};
            rem_r       <= {(XLEN+1){1'b0}};
            result_r    <= {XLEN{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            op_r        <= op_s;
            neg_r       <= neg_s;
            op_a_r      <= op_a_s;
            op_b_r      <= op_b_s;
            acc_hi_r    <= acc_hi_s;
            acc_lo_r    <= acc_lo_s;
            rem_r       <= rem_s;
            result_r    <= result_s;
            in_ready_r  <= (state_s == MD_IDLE);
            out_valid_r <= (state_s == MD_DONE);
            busy_r      <= (state_s != MD_IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign result    = result_r;

endmodule

// File: tb/tb_exu_muldiv.sv
// tb_exu_muldiv
//   Scoreboard bench for exu_muldiv (XLEN=32). The driver pushes the
//   expected result and latency from an arithmetic reference model; a
//   monitor pops and compares whenever out_valid rises, and checks that the
//   result stays stable under backpressure.
//   Build with MULDIV_FAST_MUL_EN to expect one-clock multiplies.
module tb_exu_muldiv;

    localparam int XLEN = 32;
    localparam int FW   = 3;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [FW-1:0]   funct;
    logic [XLEN-1:0] src1, src2, result;

    exu_muldiv #(.XLEN(XLEN), .FUNCT_WIDTH(FW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int op_id  = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
        int          id;
    } exp_t;
    exp_t exp_q[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Reference: RISC-V M semantics with 64-bit integer arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, ua, ub, p;
        longint unsigned pu;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = ua * ub; return pu[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f < 3'd4) return MUL_LAT;
        if (b == 32'd0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return ~32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pop on out_valid rise, check hold stability while stalled
    exp_t     e_m;
    logic     ov_prev  = 1'b0;
    logic     or_prev  = 1'b0;
    logic [31:0] res_prev = 32'd0;
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid actual=%h expected=no_result", result);
                end else begin
                    e_m = exp_q.pop_front();
                    check($sformatf("op%0d_result", e_m.id), result, e_m.res);
                    check($sformatf("op%0d_latency", e_m.id), 32'(cyc - e_m.t0), 32'(e_m.lat));
                end
            end else if (out_valid && ov_prev && !or_prev) begin
                check("hold_result", result, res_prev);
            end
            if (out_valid) begin
                check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
                check("busy_in_done", {31'd0, busy}, 32'd1);
            end
            ov_prev  = out_valid;
            or_prev  = out_ready;
            res_prev = result;
        end
    end

    task automatic recover();
        flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Issue one operation, stall the consumer for 'hold' clocks, then take it
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout actual=0 expected=1");
            recover();
            return;
        end
        funct = f; src1 = a; src2 = b; in_valid = 1'b1;
        op_id++;
        e.res = ref_result(f, a, b); e.lat = ref_latency(f, a, b); e.t0 = cyc; e.id = op_id;
        exp_q.push_back(e);
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 100) begin
            in_valid = 1'($urandom_range(0, 1));
            funct = 3'($urandom); src1 = $urandom; src2 = $urandom;
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL op%0d_out_valid_timeout actual=0 expected=1", op_id);
            void'(exp_q.pop_back());
            recover();
            return;
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            funct = 3'($urandom); src1 = $urandom; src2 = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_out_valid", {31'd0, out_valid}, 32'd0);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // Start an iterative divide that is cancelled by flush in CALC clock 10
    task automatic flush_test();
        funct = 3'd5; src1 = $urandom; src2 = $urandom | 32'd1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_before_flush", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check("flush_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        // flush beats a simultaneous request in IDLE
        funct = 3'd0; src1 = 32'd3; src2 = 32'd3; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_vs_in_valid_busy", {31'd0, busy}, 32'd0);
        check("flush_vs_in_valid_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_test();
        funct = 3'd5; src1 = $urandom; src2 = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        funct = '0; src1 = 32'd0; src2 = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(3'd5, 32'd5, 32'd0, 0);
        do_op(3'd7, 32'd5, 32'd0, 0);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(3'd7, 32'd100, 32'd7, 0);
        do_op(3'd5, 32'd1000, 32'd3, 5);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5);
        flush_test();
        reset_test();
        for (int k = 0; k < 40; k++) begin
            do_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 3));
        end
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
